// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_pkg
// Purpose  : Shared LSU bus size encodings and SRAM controller FSM encodings.
// Revision : 1.0 - initial release
// ============================================================================
package bus_pkg;

  localparam int SRAM_ADDR_W = 19;

  localparam logic [1:0] HB_BYTE = 2'b00;
  localparam logic [1:0] HB_HALF = 2'b01;
  localparam logic [1:0] HB_WORD = 2'b10;

  // Phases of one SRAM byte cycle, plus the bus-level completion state.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4
  } sram_state_e;

  // Top-level request sequencing; BUSY spans the SETUP/STROBE/RELEASE phases.
  typedef enum logic [1:0] {
    CTRL_IDLE = 2'd0,
    CTRL_BUSY = 2'd1,
    CTRL_DONE = 2'd2
  } ctrl_state_e;

  function automatic logic [1:0] last_byte_idx(input logic [1:0] hb);
    case (hb)
      HB_BYTE: return 2'd0;
      HB_HALF: return 2'd1;
      HB_WORD: return 2'd3;
      default: return 2'd3;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_byte_cycle.sv
`default_nettype none
// ============================================================================
// Module   : sram_byte_cycle
// Purpose  : Runs one SETUP/STROBE/RELEASE single-byte SRAM access.
// Revision : 1.0 - initial release
// ============================================================================
module sram_byte_cycle
  import bus_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = SRAM_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wbyte_i,
  output logic              done_o,
  output logic [7:0]        rbyte_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        dq_i,
  output logic [7:0]        dq_o,
  output logic              dq_oe_o,
  output logic              mem_ce_no,
  output logic              mem_oe_no,
  output logic              mem_we_no
);

  localparam int              CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  sram_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wbyte_q, wbyte_d;
  logic [7:0]        rbyte_q, rbyte_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wbyte_q <= '0;
      rbyte_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wbyte_q <= wbyte_d;
      rbyte_q <= rbyte_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wbyte_d = wbyte_q;
    rbyte_d = rbyte_q;
    case (state_q)
      ST_SETUP: begin
        state_d = ST_STROBE;
        cnt_d   = '0;
      end
      ST_STROBE: begin
        if (cnt_q == CNT_LAST) begin
          if (!we_q) rbyte_d = dq_i;
          state_d = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Accepting start from RELEASE chains bytes without an idle gap.
    if (start_i && (state_q == ST_IDLE || state_q == ST_RELEASE)) begin
      state_d = ST_SETUP;
      we_d    = we_i;
      addr_d  = addr_i;
      wbyte_d = wbyte_i;
    end
  end

  assign done_o     = (state_q == ST_RELEASE);
  assign rbyte_o    = rbyte_q;
  assign mem_addr_o = addr_q;
  assign dq_o       = wbyte_q;
  assign dq_oe_o    = we_q && (state_q != ST_IDLE);
  assign mem_ce_no  = (state_q == ST_IDLE);
  assign mem_oe_no  = !((state_q == ST_STROBE) && !we_q);
  assign mem_we_no  = !((state_q == ST_STROBE) && we_q);

endmodule
`default_nettype wire

// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_ctrl
// Purpose  : LSU-bus slave splitting byte/half/word accesses into 8-bit SRAM
//            cycles. Optional word read buffer: define SRAM_CTRL_READBUF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sram_ctrl
  import bus_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = SRAM_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cs_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [1:0]        hb_i,
  output logic [31:0]       rdata_o,
  output logic              stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  inout  wire  [7:0]        mem_dq_io,
  output logic              mem_ce_no,
  output logic              mem_oe_no,
  output logic              mem_we_no
);

  ctrl_state_e       state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        k_q, k_d;
  logic [1:0]        last_q, last_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              accept;
  logic [1:0]        k_next;
  logic              bc_start, bc_we, bc_done;
  logic [ADDR_W-1:0] bc_addr;
  logic [7:0]        bc_wbyte, bc_rbyte;
  logic [7:0]        dq_out, dq_in;
  logic              dq_oe;
  logic              buf_hit;
  logic [31:0]       buf_data;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^addr_i[31:ADDR_W];
  assign accept         = (state_q == CTRL_IDLE) && cs_i;
  assign k_next         = k_q + 2'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CTRL_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      k_q     <= '0;
      last_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      k_q     <= k_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    k_d      = k_q;
    last_d   = last_q;
    rdata_d  = rdata_q;
    bc_start = 1'b0;
    bc_we    = we_q;
    bc_addr  = addr_q + ADDR_W'(k_next);
    bc_wbyte = wdata_q[{k_next, 3'b000} +: 8];
    case (state_q)
      CTRL_IDLE: begin
        if (cs_i) begin
          we_d    = we_i;
          addr_d  = addr_i[ADDR_W-1:0];
          wdata_d = wdata_i;
          k_d     = 2'd0;
          last_d  = last_byte_idx(hb_i);
          if (!we_i) rdata_d = '0;
          if (buf_hit) begin
            rdata_d = buf_data;
            state_d = CTRL_DONE;
          end else begin
            bc_start = 1'b1;
            bc_we    = we_i;
            bc_addr  = addr_i[ADDR_W-1:0];
            bc_wbyte = wdata_i[7:0];
            state_d  = CTRL_BUSY;
          end
        end
      end
      CTRL_BUSY: begin
        if (bc_done) begin
          if (!we_q) rdata_d[{k_q, 3'b000} +: 8] = bc_rbyte;
          if (k_q != last_q) begin
            k_d      = k_next;
            bc_start = 1'b1;
          end else begin
            // A master that dropped cs_i mid-access gets no DONE cycle.
            state_d = cs_i ? CTRL_DONE : CTRL_IDLE;
          end
        end
      end
      default: state_d = CTRL_IDLE;
    endcase
  end

`ifdef SRAM_CTRL_READBUF_EN
  logic              buf_valid_q, buf_valid_d;
  logic [ADDR_W-3:0] buf_tag_q, buf_tag_d;
  logic [31:0]       buf_data_q, buf_data_d;
  logic              buf_fill;

  assign buf_fill = (state_q == CTRL_BUSY) && bc_done && (k_q == last_q) && !we_q
                    && (last_q == 2'd3) && (addr_q[1:0] == 2'b00);
  assign buf_hit  = buf_valid_q && !we_i && hb_i[1] && (addr_i[1:0] == 2'b00)
                    && (buf_tag_q == addr_i[ADDR_W-1:2]);
  assign buf_data = buf_data_q;

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    if (accept && we_i) begin
      buf_valid_d = 1'b0;
    end else if (buf_fill) begin
      buf_valid_d = 1'b1;
      buf_tag_d   = addr_q[ADDR_W-1:2];
      buf_data_d  = {bc_rbyte, rdata_q[23:0]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
    end
  end
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
`endif

  sram_byte_cycle #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .ADDR_W      (ADDR_W)
  ) u_byte_cycle (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (bc_start),
    .we_i       (bc_we),
    .addr_i     (bc_addr),
    .wbyte_i    (bc_wbyte),
    .done_o     (bc_done),
    .rbyte_o    (bc_rbyte),
    .mem_addr_o (mem_addr_o),
    .dq_i       (dq_in),
    .dq_o       (dq_out),
    .dq_oe_o    (dq_oe),
    .mem_ce_no  (mem_ce_no),
    .mem_oe_no  (mem_oe_no),
    .mem_we_no  (mem_we_no)
  );

  assign mem_dq_io = dq_oe ? dq_out : 8'bz;
  assign dq_in     = mem_dq_io;
  assign rdata_o   = rdata_q;
  assign stall_o   = rst_ni && (accept || (state_q == CTRL_BUSY));

endmodule
`default_nettype wire
